fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
// - Front end of the pipeline. Generates the PC and issues instruction-memory reads.
// - Buffers returned instructions in a small in-order queue.
// - Presents one instruction per cycle to dispatch as fetch_interface {done, insnbits} plus PC.
// - Handles dispatch back-pressure, branch redirects (flush) and halt-on-HLT.
// PARAMETERS
// - QDEPTH    4              instruction queue entries; power of two, >=2
// - RESET_PC  64'h0          PC loaded on reset
// PORTS
// - in_clk             in   1   clock
// - in_rst             in   1   synchronous reset, active-high
// - in_stall           in   1   dispatch cannot accept; hold the current output
// - in_redirect        in   1   branch resolved mispredicted/taken: flush and refetch
// - in_redirect_pc     in   64  new fetch PC, valid with in_redirect
// - out_imem_req       out  1   read request this cycle
// - out_imem_addr      out  64  read address (word aligned)
// - in_imem_rdata      in   32  instruction data; exactly 1 cycle after out_imem_req
// - out_fetch_sigs     out  fetch_interface  .done = 1-cycle valid pulse; .insnbits
// - out_pc             out  64  PC of out_fetch_sigs.insnbits
// - out_halted         out  1   HLT fetched; no further requests
// BEHAVIOUR
// - Reset:
//   - pc=RESET_PC; queue empty; inflight=0; state=RUN.
//   - out_fetch_sigs.done=0, insnbits=0, out_pc=0.
//   - out_imem_req=0, out_halted=0.
// - States:
//   - RUN: issue request when (count+inflight) < QDEPTH and !in_redirect; pc += 4 on issue.
//   - HALT: no requests; out_halted=1.
//   - RUN->HALT when a pushed insn matches HLT (1101_0100_010?_..._???0_0000).
//   - HALT->RUN only on in_redirect.
// - Response: one cycle after a request, {in_imem_rdata, req_pc} is pushed, unless a
//   redirect occurred in the request cycle or the response cycle, in which case it is dropped.
// - Output: each cycle with !in_stall and queue non-empty, pop the head into registered
//   outputs and set done=1 the next cycle; otherwise done=0.
//   - Stall holds insnbits/out_pc and forces done=0; no instruction is lost or duplicated.
// - Latency: reset release -> first done = 3 cycles (issue, push, pop/register).
// - Redirect (highest priority):
//   - Flush queue; cancel inflight; pc<=in_redirect_pc; state=RUN.
//   - done=0 next cycle; first request at in_redirect_pc the cycle after the redirect.
// - Simultaneous push and pop on a full queue is legal (credit counting ensures room).
// - Empty queue -> done=0; there is no bypass from the response into the output.
// - Pointers wrap modulo QDEPTH; count width is $clog2(QDEPTH)+1.
// - HLT itself is delivered to dispatch; younger insns already queued are still delivered.
// CONFIGURATION
// - FETCH_PREDICT_B_EN defined:
//   - At push, insn 0001_01?? (B) redirects the next fetch to req_pc + sext(imm26<<2).
//   - Queued/inflight younger insns are squashed (same path as redirect, internal, no PC from outside).
//   - Costs a 1-cycle bubble.
// - Undefined: B is treated as any other insn; sequential fetch continues until in_redirect.
// STRUCTURE
// - Shared package: fetch_interface, the HLT/B match constants, RESET_PC default, fetch_state_t {RUN,HALT}.
// - Sub-module fetch_queue: parameterised FIFO of {pc,insnbits}; push/pop/flush, full/empty/count.
// TESTING
// - Reset, no stall, imem returns NOP -> out_pc 0,4,8,... one per cycle from cycle 3; done held high.
// - in_stall for 5 cycles mid-stream:
//   - insnbits/out_pc frozen, done=0.
//   - Queue fills to 4, req drops to 0.
//   - Resume yields consecutive PCs with no gap or duplicate.
// - in_redirect with target 0x100 while queue holds 3 and 1 is inflight:
//   - Next done shows pc 0x100.
//   - None of the old 4 appear.
// - HLT at pc 0x8:
//   - Delivered with done.
//   - out_halted=1; no request beyond 0xC inflight.
//   - A later redirect to 0x40 resumes fetching.
// - in_rst asserted mid-stream with a full queue -> next cycle all outputs at reset values;
//   fetch restarts at RESET_PC.
// - FETCH_PREDICT_B_EN: B +0x20 at pc 0x10 -> delivered PCs 0x10, 0x30 (0x14.. never delivered);
//   without the macro -> 0x10, 0x14.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch types, HLT/B match constants and reset PC default
package fetch_unit_pkg;

    typedef struct packed {
        logic        done;
        logic [31:0] insnbits;
    } fetch_interface;

    typedef enum logic {RUN, HALT} fetch_state_t;

    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

    localparam logic [31:0] HLT_MASK  = 32'hFFE0_001F;
    localparam logic [31:0] HLT_MATCH = 32'hD440_0000;
    localparam logic [31:0] B_MASK    = 32'hFC00_0000;
    localparam logic [31:0] B_MATCH   = 32'h1400_0000;

    function automatic logic is_hlt(input logic [31:0] insn);
        return (insn & HLT_MASK) == HLT_MATCH;
    endfunction

    function automatic logic is_b(input logic [31:0] insn);
        return (insn & B_MASK) == B_MATCH;
    endfunction

    function automatic logic [63:0] b_offset(input logic [25:0] imm26);
        return {{36{imm26[25]}}, imm26, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: in-order FIFO of fetched {pc, insnbits} with push/pop/flush
module fetch_queue #(
    parameter int W     = 96,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          in_clk,
    input  logic          in_rst,
    input  logic          in_push,
    input  logic [W-1:0]  in_data,
    input  logic          in_pop,
    input  logic          in_flush,
    output logic [W-1:0]  out_data,
    output logic          out_full,
    output logic          out_empty,
    output logic [AW:0]   out_count
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;

    // Storage write; entries are not reset because count gates visibility
    always_ff @(posedge in_clk) begin
        if (in_push) mem[wr_ptr] <= in_data;
    end

    // Pointers wrap naturally modulo the power-of-two depth; flush empties in one cycle
    always_ff @(posedge in_clk) begin
        if (in_rst || in_flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            out_count <= '0;
        end else begin
            if (in_push) wr_ptr <= wr_ptr + 1'b1;
            if (in_pop) rd_ptr <= rd_ptr + 1'b1;
            out_count <= out_count + {{AW{1'b0}}, in_push} - {{AW{1'b0}}, in_pop};
        end
    end

    assign out_data  = mem[rd_ptr];
    assign out_empty = out_count == '0;
    assign out_full  = out_count == FULL_CNT;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, imem requests, instruction queue and dispatch output (FETCH_PREDICT_B_EN adds B prediction at push)
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          QDEPTH   = 4,
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic           in_clk,
    input  logic           in_rst,
    input  logic           in_stall,
    input  logic           in_redirect,
    input  logic [63:0]    in_redirect_pc,
    output logic           out_imem_req,
    output logic [63:0]    out_imem_addr,
    input  logic [31:0]    in_imem_rdata,
    output fetch_interface out_fetch_sigs,
    output logic [63:0]    out_pc,
    output logic           out_halted
);

    localparam int          CW   = $clog2(QDEPTH) + 1;
    localparam logic [CW:0] QLIM = QDEPTH[CW:0];

    fetch_state_t   state, state_nxt;
    logic [63:0]    pc, pc_nxt, req_pc, pc_q, b_target;
    logic           inflight, push, pop, b_take, q_full, q_empty;
    logic [CW-1:0]  q_count;
    logic [95:0]    q_head;
    fetch_interface sigs_q;

    assign pop  = !in_stall && !q_empty && !in_redirect;
    assign push = inflight && !in_redirect && (!q_full || pop);

`ifdef FETCH_PREDICT_B_EN
    assign b_take   = push && is_b(in_imem_rdata);
    assign b_target = req_pc + b_offset(in_imem_rdata[25:0]);
`else
    assign b_take   = 1'b0;
    assign b_target = req_pc;
`endif

    // FSM state register
    always_ff @(posedge in_clk) begin
        state <= in_rst ? RUN : state_nxt;
    end

    // Next state, request and next PC; external redirect outranks everything
    always_comb begin
        out_imem_req = !in_rst && state == RUN && !in_redirect && !b_take &&
                       ({1'b0, q_count} + {{CW{1'b0}}, inflight}) < QLIM;
        state_nxt    = in_redirect ? RUN : (push && is_hlt(in_imem_rdata)) ? HALT : state;
        pc_nxt       = in_redirect ? in_redirect_pc : b_take ? b_target :
                       out_imem_req ? pc + 64'd4 : pc;
        out_halted   = state == HALT;
    end

    // PC, single outstanding request tracking and registered dispatch outputs
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            sigs_q   <= '0;
            pc_q     <= '0;
        end else begin
            pc          <= pc_nxt;
            inflight    <= out_imem_req;
            sigs_q.done <= pop;
            if (out_imem_req) req_pc <= pc;
            if (pop) begin
                sigs_q.insnbits <= q_head[31:0];
                pc_q            <= q_head[95:32];
            end
        end
    end

    fetch_queue #(.W(96), .DEPTH(QDEPTH)) u_queue (
        .in_clk    (in_clk),
        .in_rst    (in_rst),
        .in_push   (push),
        .in_data   ({req_pc, in_imem_rdata}),
        .in_pop    (pop),
        .in_flush  (in_redirect),
        .out_data  (q_head),
        .out_full  (q_full),
        .out_empty (q_empty),
        .out_count (q_count)
    );

    assign out_imem_addr  = pc;
    assign out_fetch_sigs = sigs_q;
    assign out_pc         = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table, directed corner sequences and randomized model check for fetch_unit
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] NOP    = 32'hD503_201F;
    localparam logic [31:0] HLT    = 32'hD440_0000;
    localparam logic [31:0] B_INSN = 32'h1400_0008;

    logic           clk = 1'b0;
    logic           in_rst, in_stall, in_redirect;
    logic [63:0]    in_redirect_pc;
    logic           out_imem_req;
    logic [63:0]    out_imem_addr;
    logic [31:0]    imem_rdata;
    fetch_interface out_fetch_sigs;
    logic [63:0]    out_pc;
    logic           out_halted;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] hlt_addr = '1;
    logic [63:0] b_addr = '1;
    logic        rand_mode = 1'b0;

    fetch_unit dut (
        .in_clk         (clk),
        .in_rst         (in_rst),
        .in_stall       (in_stall),
        .in_redirect    (in_redirect),
        .in_redirect_pc (in_redirect_pc),
        .out_imem_req   (out_imem_req),
        .out_imem_addr  (out_imem_addr),
        .in_imem_rdata  (imem_rdata),
        .out_fetch_sigs (out_fetch_sigs),
        .out_pc         (out_pc),
        .out_halted     (out_halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] prog(input logic [63:0] a);
        if (a == hlt_addr) return HLT;
        if (a == b_addr) return B_INSN;
        if (rand_mode) return {3'b111, a[30:2] ^ 29'h0ABC_DEF};
        return NOP;
    endfunction

    // Instruction memory: data valid exactly one cycle after the request
    always @(posedge clk) begin
        if (out_imem_req) imem_rdata <= prog(out_imem_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        in_rst = 1'b1;
        in_stall = 1'b0;
        in_redirect = 1'b0;
        in_redirect_pc = '0;
        tick();
        tick();
        in_rst = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_done(input int lim, output logic [63:0] p, output logic [31:0] ins);
        int k = 0;
        while (!out_fetch_sigs.done && k < lim) begin
            tick();
            k++;
        end
        chk("done_timeout", {63'b0, out_fetch_sigs.done}, 64'd1);
        p = out_pc;
        ins = out_fetch_sigs.insnbits;
    endtask

    task automatic expect_seq(input logic [63:0] start, input int n);
        logic [63:0] p;
        logic [31:0] ins;
        for (int j = 0; j < n; j++) begin
            wait_done(6, p, ins);
            chk("seq_pc", p, start + 64'(j) * 4);
            chk("seq_insn", {32'b0, ins}, {32'b0, prog(start + 64'(j) * 4)});
            tick();
        end
    endtask

    typedef struct {
        logic        stall;
        logic        done;
        logic [63:0] pc;
        logic        req;
        logic [63:0] addr;
    } vec_t;

    vec_t        tv[19];
    logic        s, r, prev_stall, prev_redir;
    logic [63:0] t, exp_pc, nreq, last_pc, p;
    logic [31:0] last_ins, ins;
    int          delivered;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0]  = '{1'b0, 1'b0, 64'h00, 1'b1, 64'h00};
        tv[1]  = '{1'b0, 1'b0, 64'h00, 1'b1, 64'h04};
        tv[2]  = '{1'b0, 1'b0, 64'h00, 1'b1, 64'h08};
        tv[3]  = '{1'b0, 1'b1, 64'h00, 1'b1, 64'h0C};
        tv[4]  = '{1'b0, 1'b1, 64'h04, 1'b1, 64'h10};
        tv[5]  = '{1'b0, 1'b1, 64'h08, 1'b1, 64'h14};
        tv[6]  = '{1'b0, 1'b1, 64'h0C, 1'b1, 64'h18};
        tv[7]  = '{1'b0, 1'b1, 64'h10, 1'b1, 64'h1C};
        tv[8]  = '{1'b1, 1'b1, 64'h14, 1'b1, 64'h20};
        tv[9]  = '{1'b1, 1'b0, 64'h14, 1'b1, 64'h24};
        tv[10] = '{1'b1, 1'b0, 64'h14, 1'b0, 64'h00};
        tv[11] = '{1'b1, 1'b0, 64'h14, 1'b0, 64'h00};
        tv[12] = '{1'b1, 1'b0, 64'h14, 1'b0, 64'h00};
        tv[13] = '{1'b0, 1'b0, 64'h14, 1'b0, 64'h00};
        tv[14] = '{1'b0, 1'b1, 64'h18, 1'b1, 64'h28};
        tv[15] = '{1'b0, 1'b1, 64'h1C, 1'b1, 64'h2C};
        tv[16] = '{1'b0, 1'b1, 64'h20, 1'b1, 64'h30};
        tv[17] = '{1'b0, 1'b1, 64'h24, 1'b1, 64'h34};
        tv[18] = '{1'b0, 1'b1, 64'h28, 1'b1, 64'h38};

        // reset values while reset is held
        in_rst = 1'b1;
        in_stall = 1'b0;
        in_redirect = 1'b0;
        in_redirect_pc = '0;
        tick();
        tick();
        chk("rst_done", {63'b0, out_fetch_sigs.done}, 64'd0);
        chk("rst_insn", {32'b0, out_fetch_sigs.insnbits}, 64'd0);
        chk("rst_pc", out_pc, 64'd0);
        chk("rst_req", {63'b0, out_imem_req}, 64'd0);
        chk("rst_halted", {63'b0, out_halted}, 64'd0);

        // streaming NOPs with a 5-cycle stall
        do_reset();
        for (int i = 0; i < 19; i++) begin
            in_stall = tv[i].stall;
            #1;
            chk("tbl_done", {63'b0, out_fetch_sigs.done}, {63'b0, tv[i].done});
            chk("tbl_pc", out_pc, tv[i].pc);
            chk("tbl_req", {63'b0, out_imem_req}, {63'b0, tv[i].req});
            if (tv[i].req) chk("tbl_addr", out_imem_addr, tv[i].addr);
            if (tv[i].done) chk("tbl_insn", {32'b0, out_fetch_sigs.insnbits}, {32'b0, NOP});
            tick();
        end

        // redirect with 3 queued and 1 inflight
        do_reset();
        run(8);
        in_stall = 1'b1;
        run(2);
        in_redirect = 1'b1;
        in_redirect_pc = 64'h100;
        #1;
        chk("redir_req_blocked", {63'b0, out_imem_req}, 64'd0);
        tick();
        in_redirect = 1'b0;
        in_stall = 1'b0;
        #1;
        chk("redir_done_bubble", {63'b0, out_fetch_sigs.done}, 64'd0);
        chk("redir_req", {63'b0, out_imem_req}, 64'd1);
        chk("redir_addr", out_imem_addr, 64'h100);
        expect_seq(64'h100, 4);

        // HLT at 0x8
        hlt_addr = 64'h8;
        do_reset();
        run(3);
        chk("hlt_req_c", {63'b0, out_imem_req}, 64'd1);
        chk("hlt_addr_c", out_imem_addr, 64'hC);
        tick();
        chk("hlt_halted", {63'b0, out_halted}, 64'd1);
        chk("hlt_req_off", {63'b0, out_imem_req}, 64'd0);
        tick();
        chk("hlt_done", {63'b0, out_fetch_sigs.done}, 64'd1);
        chk("hlt_pc", out_pc, 64'h8);
        chk("hlt_insn", {32'b0, out_fetch_sigs.insnbits}, {32'b0, HLT});
        tick();
        chk("hlt_young_done", {63'b0, out_fetch_sigs.done}, 64'd1);
        chk("hlt_young_pc", out_pc, 64'hC);
        tick();
        chk("hlt_drained", {63'b0, out_fetch_sigs.done}, 64'd0);
        run(3);
        chk("hlt_still_off", {63'b0, out_imem_req}, 64'd0);
        in_redirect = 1'b1;
        in_redirect_pc = 64'h40;
        tick();
        in_redirect = 1'b0;
        #1;
        chk("hlt_resume_halted", {63'b0, out_halted}, 64'd0);
        chk("hlt_resume_req", {63'b0, out_imem_req}, 64'd1);
        chk("hlt_resume_addr", out_imem_addr, 64'h40);
        expect_seq(64'h40, 3);
        hlt_addr = '1;

        // reset mid-stream with a full queue
        do_reset();
        run(8);
        in_stall = 1'b1;
        run(4);
        chk("full_req_off", {63'b0, out_imem_req}, 64'd0);
        in_rst = 1'b1;
        tick();
        chk("mrst_done", {63'b0, out_fetch_sigs.done}, 64'd0);
        chk("mrst_insn", {32'b0, out_fetch_sigs.insnbits}, 64'd0);
        chk("mrst_pc", out_pc, 64'd0);
        chk("mrst_req", {63'b0, out_imem_req}, 64'd0);
        in_rst = 1'b0;
        in_stall = 1'b0;
        #1;
        chk("mrst_restart_req", {63'b0, out_imem_req}, 64'd1);
        chk("mrst_restart_addr", out_imem_addr, 64'h0);
        expect_seq(64'h0, 3);

        // B +0x20 at 0x10
        b_addr = 64'h10;
        do_reset();
        expect_seq(64'h0, 5);
        wait_done(8, p, ins);
`ifdef FETCH_PREDICT_B_EN
        chk("b_next_pc", p, 64'h30);
`else
        chk("b_next_pc", p, 64'h14);
`endif
        b_addr = '1;

        // randomized stall/redirect against the in-order delivery model
        rand_mode = 1'b1;
        do_reset();
        exp_pc = 64'h0;
        nreq = 64'h0;
        prev_stall = 1'b0;
        prev_redir = 1'b0;
        last_pc = '0;
        last_ins = '0;
        delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            s = $urandom_range(0, 9) < 3;
            r = $urandom_range(0, 99) < 3;
            t = 64'h1000 + 64'($urandom_range(0, 255)) * 4;
            in_stall = s;
            in_redirect = r;
            in_redirect_pc = t;
            #1;
            if (prev_stall || prev_redir) chk("rnd_bubble", {63'b0, out_fetch_sigs.done}, 64'd0);
            if (prev_stall) begin
                chk("rnd_hold_pc", out_pc, last_pc);
                chk("rnd_hold_insn", {32'b0, out_fetch_sigs.insnbits}, {32'b0, last_ins});
            end
            if (out_fetch_sigs.done) begin
                chk("rnd_pc", out_pc, exp_pc);
                chk("rnd_insn", {32'b0, out_fetch_sigs.insnbits}, {32'b0, prog(exp_pc)});
                exp_pc = exp_pc + 4;
                delivered++;
            end
            if (out_imem_req) begin
                chk("rnd_req_addr", out_imem_addr, nreq);
                nreq = nreq + 4;
            end
            if (r) begin
                chk("rnd_req_redir", {63'b0, out_imem_req}, 64'd0);
                exp_pc = t;
                nreq = t;
            end
            prev_stall = s;
            prev_redir = r;
            last_pc = out_pc;
            last_ins = out_fetch_sigs.insnbits;
            tick();
        end
        in_stall = 1'b0;
        in_redirect = 1'b0;
        chk("rnd_progress", {63'b0, delivered >= 600}, 64'd1);
        wait_done(8, p, ins);
        chk("rnd_drain_pc", p, exp_pc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
